// File: rtl/mclk_sel_ctrl.sv
// Master-clock selection controller: qualifies candidate clock sources, picks a target
// and sequences a gated buffer-tree switchover followed by an application reset.
module mclk_sel_ctrl #(
    parameter int NSRC        = 4,
    parameter int SELW        = 2,
    parameter int DEFAULT_SRC = 0,
    parameter int STABLE_CNT  = 1024,
    parameter int SWITCH_GAP  = 16,
    parameter int RST_LEN     = 64,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_ok,
    input  logic [NSRC-1:0] src_locked,
    input  logic [NSRC-1:0] cfg_en_mask,
    input  logic            cfg_auto,
    input  logic [SELW-1:0] cfg_force_sel,
    input  logic            cfg_restart,
    output logic [NSRC-1:0] clk_ce,
    output logic [SELW-1:0] clksel,
    output logic            app_rst,
    output logic            switching,
    output logic [NSRC-1:0] src_stable,
    output logic [7:0]      switch_count
);
    localparam logic [SELW-1:0] DEF_SEL  = SELW'(DEFAULT_SRC);
    localparam logic [CNTW-1:0] STABLE_C = CNTW'(STABLE_CNT);
    localparam logic [CNTW-1:0] GAP_LAST = CNTW'(SWITCH_GAP - 1);
    localparam logic [CNTW-1:0] RST_LAST = CNTW'(RST_LEN - 1);
    localparam logic [SELW:0]   NSRC_W   = (SELW + 1)'(NSRC);

    typedef enum logic [1:0] {RUN, GATE_OFF, SETTLE, APPRST} state_t;

    function automatic logic [NSRC-1:0] onehot(input logic [SELW-1:0] idx);
        logic [NSRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t                    state_q;
    logic [CNTW-1:0]           seq_cnt_q;
    logic [SELW-1:0]           pend_sel_q;
    logic [SELW-1:0]           clksel_q;
    logic [NSRC-1:0]           clk_ce_q;
    logic                      app_rst_q;
    logic                      switching_q;
    logic [7:0]                switch_count_q;
    logic [NSRC-1:0]           healthy;
    logic [NSRC-1:0][CNTW-1:0] stab_cnt_q;
    logic [NSRC-1:0][CNTW-1:0] stab_cnt_d;
    logic [NSRC-1:0]           stable_q;
    logic [NSRC-1:0]           stable_d;
    logic [SELW-1:0]           target;
    logic [SELW-1:0]           landing_sel;

    // Any unhealthy cycle restarts qualification; the fallback source is always usable.
    always_comb begin
        healthy    = src_ok & src_locked & cfg_en_mask;
        stab_cnt_d = stab_cnt_q;
        stable_d   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!healthy[i])
                stab_cnt_d[i] = '0;
            else if (stab_cnt_q[i] != STABLE_C)
                stab_cnt_d[i] = stab_cnt_q[i] + 1'b1;
            stable_d[i] = (stab_cnt_d[i] == STABLE_C);
        end
        stable_d[DEFAULT_SRC] = 1'b1;
    end

    always_comb begin
        target = DEF_SEL;
        if (cfg_auto) begin
            for (int i = 0; i < NSRC; i++)
                if (stable_q[i]) target = SELW'(i);
        end else if (({1'b0, cfg_force_sel} < NSRC_W) && stable_q[cfg_force_sel]) begin
            target = cfg_force_sel;
        end
        landing_sel = stable_q[pend_sel_q] ? pend_sel_q : DEF_SEL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stab_cnt_q     <= '0;
            stable_q       <= onehot(DEF_SEL);
            state_q        <= APPRST;
            seq_cnt_q      <= '0;
            pend_sel_q     <= DEF_SEL;
            clksel_q       <= DEF_SEL;
            clk_ce_q       <= onehot(DEF_SEL);
            app_rst_q      <= 1'b1;
            switching_q    <= 1'b1;
            switch_count_q <= '0;
        end else begin
            stab_cnt_q <= stab_cnt_d;
            stable_q   <= stable_d;
            case (state_q)
                RUN: begin
                    if (target != clksel_q) begin
                        state_q     <= GATE_OFF;
                        pend_sel_q  <= target;
                        clk_ce_q    <= '0;
                        switching_q <= 1'b1;
                        seq_cnt_q   <= '0;
                    end else if (cfg_restart) begin
                        state_q     <= APPRST;
                        app_rst_q   <= 1'b1;
                        switching_q <= 1'b1;
                        seq_cnt_q   <= '0;
                    end
                end
                GATE_OFF: begin
                    // Last gated cycle: fall back if the pending source lost stability.
                    if (seq_cnt_q == GAP_LAST) begin
                        state_q    <= SETTLE;
                        pend_sel_q <= landing_sel;
                        clksel_q   <= landing_sel;
                        clk_ce_q   <= onehot(landing_sel);
                        if (switch_count_q != 8'hFF)
                            switch_count_q <= switch_count_q + 1'b1;
                        seq_cnt_q  <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (seq_cnt_q == GAP_LAST) begin
                        state_q   <= APPRST;
                        app_rst_q <= 1'b1;
                        seq_cnt_q <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                APPRST: begin
                    if (seq_cnt_q == RST_LAST) begin
                        state_q     <= RUN;
                        app_rst_q   <= 1'b0;
                        switching_q <= 1'b0;
                        seq_cnt_q   <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                default: state_q <= APPRST;
            endcase
        end
    end

    assign clk_ce       = clk_ce_q;
    assign clksel       = clksel_q;
    assign app_rst      = app_rst_q;
    assign switching    = switching_q;
    assign src_stable   = stable_q;
    assign switch_count = switch_count_q;
endmodule

// File: doc/mclk_sel_ctrl.md
Name: mclk_sel_ctrl

Overview:
- Parametrised master-clock selection controller for NSRC candidate clock sources: local oscillator, DTC clock, Ethernet-recovered clock, spares.
- Qualifies each source's ok/locked status over time, picks a target by priority (auto) or by config (manual), and runs a gated switchover sequence.
- Drives one-hot clock enables and a binary select into a BUFGCTRL tree, then issues an application reset once the new clock is in place.
- Runs on the always-present local clock.

Parameters:
- NSRC, 4, number of clock sources (2..8).
- SELW, 2, select width (ceil(log2(NSRC))).
- DEFAULT_SRC, 0, fallback source index; always treated as stable.
- STABLE_CNT, 1024, consecutive healthy cycles before a source counts as stable.
- SWITCH_GAP, 16, cycles with all enables off, and also cycles of settle after select.
- RST_LEN, 64, app_rst pulse length in cycles.
- CNTW, 16, width of the internal counters.

Ports:
- clk  in  1  local free-running clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- src_ok  in  NSRC  per-source frequency-ok flag.
- src_locked  in  NSRC  per-source PLL/DCM lock.
- cfg_en_mask  in  NSRC  per-source enable; 0 means never healthy.
- cfg_auto  in  1  1 = priority auto-select, 0 = manual.
- cfg_force_sel  in  SELW  manual target index.
- cfg_restart  in  1  single-cycle request to re-issue app_rst without switching.
- clk_ce  out  NSRC  one-hot clock enables to the buffer tree; all zero while gated.
- clksel  out  SELW  binary select of the active source.
- app_rst  out  1  application reset, active high.
- switching  out  1  high whenever FSM is not in RUN.
- src_stable  out  NSRC  per-source stable status.
- switch_count  out  8  saturating count of completed switchovers.

Behaviour:
- All outputs registered. Synchronous active-high reset on clk; rst has priority over every other event, including mid-switch.
- Reset values:
  - clksel = DEFAULT_SRC; clk_ce = onehot(DEFAULT_SRC).
  - app_rst = 1; switching = 1.
  - switch_count = 0; src_stable = onehot(DEFAULT_SRC).
  - All counters 0; state APPRST.
- Health: healthy[i] = src_ok[i] & src_locked[i] & cfg_en_mask[i].
- Stability counter per source:
  - Increments while healthy[i], saturating at STABLE_CNT.
  - Clears to 0 on any unhealthy cycle.
  - src_stable[i] = (count == STABLE_CNT); the DEFAULT_SRC bit is forced to 1.
- Target, combinational from registered stable flags:
  - Auto: highest-index stable source (DEFAULT_SRC if no other is stable).
  - Manual: cfg_force_sel if < NSRC and stable, else DEFAULT_SRC.
- FSM states: RUN, GATE_OFF, SETTLE, APPRST.
  - RUN:
    - If target != clksel: go to GATE_OFF next cycle and latch target into pend_sel.
    - Else if cfg_restart: go to APPRST.
    - Switch takes priority over restart when both occur in the same cycle.
    - Loss of the current source makes it unstable, so target changes and a switch starts the next cycle.
  - GATE_OFF:
    - clk_ce = 0 for exactly SWITCH_GAP cycles; clksel unchanged.
    - On the last GATE_OFF cycle, re-check: if pend_sel is no longer stable, replace it with DEFAULT_SRC.
    - Then go to SETTLE.
  - SETTLE:
    - On entry, clksel = pend_sel and clk_ce = onehot(pend_sel) in the same cycle.
    - switch_count increments, saturating at 255.
    - Held for SWITCH_GAP cycles, then go to APPRST.
  - APPRST: app_rst = 1 for exactly RST_LEN cycles, then go to RUN with app_rst = 0.
- cfg_restart is ignored outside RUN. Target changes during GATE_OFF, SETTLE or APPRST are not acted on until RUN.
- Latencies: switch decision to first gated cycle = 1 clk. Gated cycle to new clksel = SWITCH_GAP clk.
- After rst deasserts: app_rst stays high RST_LEN cycles, then RUN.
- clk_ce is never multi-hot; it is either all zero or exactly one bit.

Test Plan:
Bench configuration: NSRC=4, STABLE_CNT=8, SWITCH_GAP=4, RST_LEN=6, DEFAULT_SRC=0.
1. Release rst with all sources unhealthy -> app_rst high 6 cycles then low; clksel=0, clk_ce=0001, switching low after cycle 6, switch_count=0.
2. Auto mode, src2 healthy continuously -> src_stable[2] after 8 cycles; next cycle clk_ce=0000 for 4 cycles; then clksel=2, clk_ce=0100; 4 settle cycles; app_rst 6 cycles; switch_count=1.
3. Selected src2 drops src_locked for 1 cycle -> GATE_OFF the following cycle; lands on clksel=0 (or 3 if src3 stable); switch_count=2.
4. Manual cfg_force_sel=3 with src3 flickering (healthy 5, unhealthy 1, repeating) -> never stable, clksel stays 0. Src3 then healthy 8 cycles -> switch to 3.
5. Start switch to src1, drop src1 ok during GATE_OFF -> SETTLE enters with clksel=0, clk_ce=0001. Separately, cfg_restart pulse in RUN -> app_rst 6 cycles, clksel and switch_count unchanged.
6. Assert rst during SETTLE -> next cycle clksel=0, clk_ce=0001, app_rst=1, src_stable=0001, switch_count=0.
